interrupt_sequencer: RTL and testbench

Schedules interrupt entry for the CPU core. It arbitrates between reset, NMI, IRQ and BRK requests at instruction boundaries and steps the core through the fixed 7-cycle entry sequence: 2 dummy cycles, push PCH, push PCL, push P, fetch vector low, fetch vector high. It owns NMI edge capture and tells the datapath which vector to load, when to push and when to set the I flag.

---
 rtl/cpu_int_pkg.sv | 33 +++
 rtl/nmi_edge_latch.sv | 24 ++
 rtl/interrupt_sequencer.sv | 104 ++++++++++
 tb/tb_interrupt_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_int_pkg.sv
// Shared types and constants for the CPU interrupt-entry sequencer.
package cpu_int_pkg;

  typedef enum logic [1:0] {
    KIND_IRQ = 2'd0,
    KIND_NMI = 2'd1,
    KIND_RST = 2'd2,
    KIND_BRK = 2'd3
  } seq_kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } seq_state_t;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RST = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  localparam logic [2:0] STEP_PUSH_FIRST = 3'd2;
  localparam logic [2:0] STEP_SET_I      = 3'd4;
  localparam logic [2:0] STEP_VEC_LO     = 3'd5;

  // BRK shares the IRQ vector.
  function automatic logic [7:0] vector_of(input seq_kind_t k);
    case (k)
      KIND_NMI: return VEC_NMI;
      KIND_RST: return VEC_RST;
      default:  return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/nmi_edge_latch.sv
// Enable-qualified falling-edge detector on nmi_n with a sticky pending flag.
module nmi_edge_latch (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic nmi_n,
  input  logic clr,
  output logic pending
);

  logic prev;

  // An edge in the same cycle as clr wins, so a back-to-back NMI is not lost.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      prev    <= 1'b1;
      pending <= 1'b0;
    end else if (en) begin
      prev    <= nmi_n;
      pending <= (pending & ~clr) | (prev & ~nmi_n);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates RST/NMI/IRQ/BRK at instruction boundaries and steps the 7-cycle entry sequence.
// Optional: INTERRUPT_SEQUENCER_NMI_HIJACK_EN lets a late NMI take over an IRQ/BRK entry.
module interrupt_sequencer
  import cpu_int_pkg::*;
#(
  parameter int SEQ_LEN = 7
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enableFFs,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       rst_req,
  input  logic       brk_req,
  input  logic       i_flag,
  input  logic       instr_boundary,
  output logic       seq_active,
  output logic [2:0] seq_step,
  output logic [1:0] seq_kind,
  output logic       push_en,
  output logic [7:0] vector_lo,
  output logic       set_i,
  output logic       b_flag,
  output logic       nmi_pending
);

  localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);

  seq_state_t state;
  seq_kind_t  kind;
  logic [2:0] step;
  logic       rst_pending;
  logic       brk_seq;

  logic idle, start_rst, arb, take_nmi, take_irq, take_brk, hijack, nmi_clr;

  always_comb begin
    idle      = (state == ST_IDLE);
    start_rst = rst_req | rst_pending;
    arb       = idle & instr_boundary & ~start_rst;
    take_nmi  = arb & nmi_pending;
    take_irq  = arb & ~nmi_pending & ~irq_n & ~i_flag;
    take_brk  = arb & ~nmi_pending & (irq_n | i_flag) & brk_req;
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
    // Kind switches on the step 3 -> 4 transition, before set_i and the vector fetch.
    hijack    = ~idle & ~start_rst & nmi_pending & (step == STEP_SET_I - 3'd1) &
                ((kind == KIND_IRQ) | (kind == KIND_BRK));
`else
    hijack    = 1'b0;
`endif
    nmi_clr   = take_nmi | hijack;
  end

  nmi_edge_latch u_nmi (
    .clk     (clk),
    .nrst    (nrst),
    .en      (enableFFs),
    .nmi_n   (nmi_n),
    .clr     (nmi_clr),
    .pending (nmi_pending)
  );

  // Reset request overrides everything, including a sequence already in flight.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      kind        <= KIND_IRQ;
      step        <= '0;
      rst_pending <= 1'b1;
      brk_seq     <= 1'b0;
    end else if (enableFFs) begin
      if (start_rst) begin
        state       <= ST_SEQ;
        kind        <= KIND_RST;
        step        <= '0;
        brk_seq     <= 1'b0;
        rst_pending <= 1'b0;
      end else if (!idle) begin
        if (hijack) kind <= KIND_NMI;
        if (step == LAST_STEP) begin
          state <= ST_IDLE;
          step  <= '0;
        end else begin
          step <= step + 3'd1;
        end
      end else if (take_nmi | take_irq | take_brk) begin
        state   <= ST_SEQ;
        step    <= '0;
        brk_seq <= take_brk;
        kind    <= take_nmi ? KIND_NMI : (take_irq ? KIND_IRQ : KIND_BRK);
      end
    end
  end

  assign seq_active = ~idle;
  assign seq_step   = step;
  assign seq_kind   = kind;
  assign push_en    = seq_active && (step >= STEP_PUSH_FIRST) && (step <= STEP_SET_I) &&
                      (kind != KIND_RST);
  assign set_i      = seq_active && (step == STEP_SET_I);
  assign vector_lo  = (seq_active && (step >= STEP_VEC_LO)) ? vector_of(kind) : 8'h00;
  assign b_flag     = seq_active & brk_seq;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized + directed bench for interrupt_sequencer against an in-bench behavioural model.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       nrst, enableFFs, nmi_n, irq_n, rst_req, brk_req, i_flag, instr_boundary;
  logic       seq_active, push_en, set_i, b_flag, nmi_pending;
  logic [2:0] seq_step;
  logic [1:0] seq_kind;
  logic [7:0] vector_lo;

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  interrupt_sequencer #(.SEQ_LEN(7)) dut (
    .clk(clk), .nrst(nrst), .enableFFs(enableFFs), .nmi_n(nmi_n), .irq_n(irq_n),
    .rst_req(rst_req), .brk_req(brk_req), .i_flag(i_flag), .instr_boundary(instr_boundary),
    .seq_active(seq_active), .seq_step(seq_step), .seq_kind(seq_kind), .push_en(push_en),
    .vector_lo(vector_lo), .set_i(set_i), .b_flag(b_flag), .nmi_pending(nmi_pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: kind 0=IRQ 1=NMI 2=RST 3=BRK
  bit m_act, m_brk, m_pend, m_prev, m_rstp, m_fall, m_clr;
  int m_step, m_kind;

  task automatic m_start(input int k);
    m_act  = 1;
    m_step = 0;
    m_kind = k;
    m_brk  = (k == 3);
  endtask

  always @(posedge clk) begin
    if (!nrst) begin
      m_act = 0; m_step = 0; m_kind = 0; m_brk = 0;
      m_pend = 0; m_prev = 1; m_rstp = 1;
    end else if (enableFFs) begin
      m_fall = m_prev && !nmi_n;
      m_clr  = 0;
      if (rst_req || m_rstp) begin
        m_start(2);
        m_rstp = 0;
      end else if (m_act) begin
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
        if (m_step == 3 && m_pend && (m_kind == 0 || m_kind == 3)) begin
          m_kind = 1;
          m_clr  = 1;
        end
`endif
        m_step = m_step + 1;
        if (m_step == 7) begin
          m_act  = 0;
          m_step = 0;
        end
      end else if (instr_boundary) begin
        if (m_pend) begin
          m_start(1);
          m_clr = 1;
        end else if (!irq_n && !i_flag) m_start(0);
        else if (brk_req) m_start(3);
      end
      m_pend = (m_pend && !m_clr) || m_fall;
      m_prev = nmi_n;
    end
  end

  function automatic logic [7:0] exp_vec();
    if (!m_act || m_step < 5) return 8'h00;
    return (m_kind == 1) ? 8'hFA : (m_kind == 2) ? 8'hFC : 8'hFE;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("seq_active", 32'(seq_active), 32'(m_act));
      chk("seq_step", 32'(seq_step), 32'(m_step));
      chk("seq_kind", 32'(seq_kind), 32'(m_kind));
      chk("push_en", 32'(push_en), 32'(m_act && m_step >= 2 && m_step <= 4 && m_kind != 2));
      chk("set_i", 32'(set_i), 32'(m_act && m_step == 4));
      chk("vector_lo", 32'(vector_lo), 32'(exp_vec()));
      chk("b_flag", 32'(b_flag), 32'(m_act && m_brk));
      chk("nmi_pending", 32'(nmi_pending), 32'(m_pend));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_step(input int s);
    int n;
    n = 0;
    while (!(seq_active && seq_step == 3'(s)) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL wait_step_timeout step=%0d act=timeout exp=reached", s);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (seq_active && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout act=busy exp=idle");
    end
  endtask

  task automatic boundary_pulse();
    instr_boundary = 1;
    tick();
    instr_boundary = 0;
  endtask

  initial begin
    nrst = 0; enableFFs = 1; nmi_n = 1; irq_n = 1; rst_req = 0;
    brk_req = 0; i_flag = 0; instr_boundary = 0;
    tick(); tick(); tick();
    chk_on = 1;
    chk("rst_active_lit", 32'(seq_active), 0);
    chk("rst_vec_lit", 32'(vector_lo), 0);
    chk("rst_pend_lit", 32'(nmi_pending), 0);

    // Power-on RST sequence
    nrst = 1;
    tick();
    chk("por_kind_lit", 32'(seq_kind), 2);
    chk("por_step_lit", 32'(seq_step), 0);
    wait_step(5);
    chk("por_vec_lit", 32'(vector_lo), 32'h FC);
    wait_idle();

    // IRQ taken, then masked
    irq_n = 0;
    boundary_pulse();
    chk("irq_kind_lit", 32'(seq_kind), 0);
    wait_step(3);
    chk("irq_push_lit", 32'(push_en), 1);
    wait_step(5);
    chk("irq_vec_lit", 32'(vector_lo), 32'h FE);
    wait_idle();
    i_flag = 1;
    boundary_pulse();
    boundary_pulse();
    chk("irq_masked_lit", 32'(seq_active), 0);
    i_flag = 0; irq_n = 1;

    // NMI edge mid-instruction, beats IRQ at boundary
    nmi_n = 0;
    tick();
    nmi_n = 1;
    chk("nmi_latch_lit", 32'(nmi_pending), 1);
    irq_n = 0;
    boundary_pulse();
    irq_n = 1;
    chk("nmi_kind_lit", 32'(seq_kind), 1);
    chk("nmi_clr_lit", 32'(nmi_pending), 0);
    wait_step(5);
    chk("nmi_vec_lit", 32'(vector_lo), 32'h FA);
    wait_idle();

    // BRK with NMI edge at step 1
    brk_req = 1;
    boundary_pulse();
    brk_req = 0;
    tick();
    nmi_n = 0;
    tick();
    nmi_n = 1;
    wait_step(5);
    chk("brk_b_lit", 32'(b_flag), 1);
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
    chk("hijack_vec_lit", 32'(vector_lo), 32'h FA);
    chk("hijack_pend_lit", 32'(nmi_pending), 0);
`else
    chk("brk_vec_lit", 32'(vector_lo), 32'h FE);
    chk("brk_pend_lit", 32'(nmi_pending), 1);
`endif
    wait_idle();
    boundary_pulse();
`ifndef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
    chk("late_nmi_lit", 32'(seq_kind), 1);
`endif
    wait_idle();

    // rst_req aborts IRQ at step 3
    irq_n = 0;
    boundary_pulse();
    irq_n = 1;
    wait_step(3);
    rst_req = 1;
    tick();
    rst_req = 0;
    chk("abort_kind_lit", 32'(seq_kind), 2);
    chk("abort_step_lit", 32'(seq_step), 0);
    wait_idle();

    // Freeze mid-sequence
    irq_n = 0;
    boundary_pulse();
    irq_n = 1;
    wait_step(2);
    enableFFs = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("freeze_step_lit", 32'(seq_step), 2);
    enableFFs = 1;
    tick();
    chk("resume_step_lit", 32'(seq_step), 3);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      enableFFs      = ($urandom_range(0, 9) < 8);
      nmi_n          = ($urandom_range(0, 9) != 0);
      irq_n          = $urandom_range(0, 1) == 1;
      i_flag         = $urandom_range(0, 1) == 1;
      instr_boundary = ($urandom_range(0, 9) < 3);
      brk_req        = ($urandom_range(0, 9) < 2);
      rst_req        = ($urandom_range(0, 99) == 0);
      nrst           = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
